// File: rtl/wr_fifo_pkg.sv
// Shared definitions for the pixel FIFO write packer and its read-side unpacker:
// pixel/word widths, colour field offsets and the write-side FSM encoding.
package wr_fifo_pkg;

    localparam int PIX_W  = 8;
    localparam int WORD_W = 24;
    localparam int R_LSB  = 16;
    localparam int G_LSB  = 8;
    localparam int B_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] pack_pixel(input logic [PIX_W-1:0] r,
                                                      input logic [PIX_W-1:0] g,
                                                      input logic [PIX_W-1:0] b);
        logic [WORD_W-1:0] w;
        w = '0;
        w[R_LSB +: PIX_W] = r;
        w[G_LSB +: PIX_W] = g;
        w[B_LSB +: PIX_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/wr_fifo_skid.sv
// Two-entry skid buffer between the pixel handshake and the FIFO write port.
// The caller never pushes when full nor pops when empty.
module wr_fifo_skid
    import wr_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [WORD_W-1:0] din_i,
    output logic [WORD_W-1:0] dout_o,
    output logic [1:0]        occ_o
);

    logic [WORD_W-1:0] head_q, head_d;
    logic [WORD_W-1:0] tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = din_i;
                else               tail_d = din_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Push and pop together keeps occupancy; the new word lands behind the survivor.
                if (occ_q == 2'd1) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign dout_o = head_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/wr_fifo_packer.sv
// Frame-aware pixel-to-FIFO write packer: one {R,G,B} word per accepted pixel, one frame per frame_start.
// Optional WR_FIFO_STALL_CNT_EN adds a saturating stall_cnt output counting cycles blocked by fifo_full.
module wr_fifo_packer
    import wr_fifo_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pixel_r,
    input  logic [PIX_W-1:0]  pixel_g,
    input  logic [PIX_W-1:0]  pixel_b,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [WORD_W-1:0] fifo_data_wr,
    output logic              frame_done,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y
`ifdef WR_FIFO_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    if (FRAME_PIXELS < 1 || H_ACTIVE > 1024 || V_ACTIVE > 512) begin : g_bad_geometry
        $error("wr_fifo_packer: frame geometry does not fit pix_x/pix_y");
    end

    state_t      state_q;
    logic [9:0]  pix_x_q;
    logic [8:0]  pix_y_q;
    logic        frame_done_q;
    logic [1:0]  occ;
    logic        accept;
    logic        last_x;
    logic        last_y;
    logic        drain_empty;

    assign pix_ready  = ~rst & (state_q == ST_ACTIVE) & (occ != 2'd2);
    assign fifo_wr_en = ~rst & (occ != 2'd0) & ~fifo_full;
    assign accept     = pix_valid & pix_ready;
    assign last_x     = (pix_x_q == 10'(H_ACTIVE - 1));
    assign last_y     = (pix_y_q == 9'(V_ACTIVE - 1));
    // Buffer is empty after this edge: lets DONE follow the final write by one cycle.
    assign drain_empty = (occ == 2'd0) | ((occ == 2'd1) & fifo_wr_en);

    wr_fifo_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (accept),
        .pop_i  (fifo_wr_en),
        .din_i  (pack_pixel(pixel_r, pixel_g, pixel_b)),
        .dout_o (fifo_data_wr),
        .occ_o  (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pix_x_q      <= 10'd0;
            pix_y_q      <= 9'd0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (accept) begin
                        if (last_x) begin
                            pix_x_q <= 10'd0;
                            if (last_y) begin
                                pix_y_q <= 9'd0;
                                state_q <= ST_DRAIN;
                            end else begin
                                pix_y_q <= pix_y_q + 9'd1;
                            end
                        end else begin
                            pix_x_q <= pix_x_q + 10'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frame_done = frame_done_q;

`ifdef WR_FIFO_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == ST_IDLE) && frame_start) begin
            stall_cnt_q <= 32'd0;
        end else if ((occ != 2'd0) && fifo_full && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wr_fifo_packer.sv
// Scoreboard bench for wr_fifo_packer with a 4x2 frame: driver queues expected words on
// each accepted pixel, a negedge monitor checks every FIFO write against the queue.
module tb_wr_fifo_packer;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pixel_r;
    logic [7:0]  pixel_g;
    logic [7:0]  pixel_b;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [23:0] fifo_data_wr;
    logic        frame_done;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
`ifdef WR_FIFO_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    wr_fifo_packer #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pixel_r      (pixel_r),
        .pixel_g      (pixel_g),
        .pixel_b      (pixel_b),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_wr (fifo_data_wr),
        .frame_done   (frame_done),
        .pix_x        (pix_x),
        .pix_y        (pix_y)
`ifdef WR_FIFO_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-chosen pixels; each word is the expected packed {R,G,B}.
    logic [23:0] tab [16] = '{24'h0C2238, 24'h112233, 24'h445566, 24'h778899,
                              24'hAABBCC, 24'hDDEEFF, 24'h010203, 24'hFF0080,
                              24'h7F7F7F, 24'h800001, 24'h123456, 24'h654321,
                              24'hC0FFEE, 24'hBADA55, 24'h00FF00, 24'hFFFFFF};

    logic [23:0] sb [$];
    int n_chk  = 0;
    int n_pass = 0;
    int n_wr   = 0;
    int k      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present pixels until n are accepted or the cycle budget runs out.
    task automatic stream(input int n, input logic full, input int budget, output int acc);
        logic [23:0] w;
        acc = 0;
        for (int c = 0; c < budget && acc < n; c++) begin
            fifo_full = full;
            w = tab[k % 16];
            pixel_r = w[23:16];
            pixel_g = w[15:8];
            pixel_b = w[7:0];
            pix_valid = 1'b1;
            if (pix_ready) begin
                sb.push_back(w);
                k++;
                acc++;
            end
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, seen, 1'b1);
        tick();
    endtask

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            n_wr++;
            if (sb.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
            else chk("wr_data", fifo_data_wr, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int wr0;
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; fifo_full = 1'b0;
        pixel_r = 8'd0; pixel_g = 8'd0; pixel_b = 8'd0;
        tick(); tick();

        // Reset state
        @(negedge clk);
        chk("rst_ready", pix_ready, 1'b0);
        chk("rst_wr_en", fifo_wr_en, 1'b0);
        chk("rst_x", pix_x, 10'd0);
        chk("rst_y", pix_y, 9'd0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_data", fifo_data_wr, 24'h0);
        tick();
        rst = 1'b0;

        // Single pixel 12/34/56 lands on the FIFO port the next cycle
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        stream(1, 1'b0, 4, acc);
        @(negedge clk);
        chk("t1_wr_en", fifo_wr_en, 1'b1);
        chk("t1_data", fifo_data_wr, 24'h0C2238);
        chk("t1_x", pix_x, 10'd1);
        tick();

        // Rest of the 4x2 frame back-to-back; frame_done two cycles after the last accept
        stream(7, 1'b0, 7, acc);
        chk("t2_acc", acc, 7);
        @(negedge clk);
        chk("t2_done_early", frame_done, 1'b0);
        tick();
        @(negedge clk);
        chk("t2_done_pulse", frame_done, 1'b1);
        tick();
        @(negedge clk);
        chk("t2_done_clear", frame_done, 1'b0);
        chk("t2_writes", n_wr, 8);
        chk("t2_sb_empty", sb.size(), 0);
        chk("t2_x_wrap", pix_x, 10'd0);
        chk("t2_y_wrap", pix_y, 9'd0);
        tick();

        // Backpressure: 10 full cycles from an empty buffer accept exactly two pixels
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        stream(2, 1'b0, 4, acc);
        tick();
        wr0 = n_wr;
        stream(10, 1'b1, 10, acc);
        fifo_full = 1'b1;
        chk("t3_acc", acc, 2);
        chk("t3_ready", pix_ready, 1'b0);
        chk("t3_wr_en", fifo_wr_en, 1'b0);
        chk("t3_no_writes", n_wr - wr0, 0);
        stream(4, 1'b0, 12, acc);
        chk("t3_resume_acc", acc, 4);
        wait_done("t3_done");
        chk("t3_sb_empty", sb.size(), 0);

        // Reset with two buffered pixels drops them without a frame_done
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        stream(3, 1'b1, 3, acc);
        chk("t4_acc", acc, 2);
        rst = 1'b1;
        fifo_full = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t4_wr_gated", fifo_wr_en, 1'b0);
        tick();
        @(negedge clk);
        chk("t4_x", pix_x, 10'd0);
        chk("t4_y", pix_y, 9'd0);
        chk("t4_ready", pix_ready, 1'b0);
        chk("t4_done", frame_done, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_idle_wr", fifo_wr_en, 1'b0);
            chk("t4_idle_done", frame_done, 1'b0);
            chk("t4_idle_ready", pix_ready, 1'b0);
            tick();
        end

        // frame_start during ACTIVE is ignored; x wraps 3->0 with y 0->1
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        stream(2, 1'b0, 4, acc);
        frame_start = 1'b1;
        stream(1, 1'b0, 4, acc);
        frame_start = 1'b0;
        chk("t5_x3", pix_x, 10'd3);
        chk("t5_y0", pix_y, 9'd0);
        stream(1, 1'b0, 4, acc);
        chk("t5_x_wrap", pix_x, 10'd0);
        chk("t5_y1", pix_y, 9'd1);
        stream(4, 1'b0, 8, acc);
        chk("t5_acc", acc, 4);
        wait_done("t5_done");
        chk("t5_sb_empty", sb.size(), 0);

`ifdef WR_FIFO_STALL_CNT_EN
        // Stall counter: ten full cycles with one word pending, cleared by the next frame_start
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("t6_cnt_start", stall_cnt, 32'd0);
        stream(1, 1'b0, 4, acc);
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_cnt10", stall_cnt, 32'd10);
        fifo_full = 1'b0;
        stream(7, 1'b0, 12, acc);
        wait_done("t6_done");
        chk("t6_cnt_hold", stall_cnt, 32'd10);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("t6_cnt_clear", stall_cnt, 32'd0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
